mem_scan_checker: RTL and testbench

Sequential scrub engine for the two 8-entry parity-protected data memories, feeding their address and bank-select inputs. On a start request it walks every address of bank 0, then bank 1, and samples the returned byte and stored parity bit. It checks each entry (pass when the stored parity equals the XOR of the eight data bits), counts failures and records the first failing location. It replaces the free-running ripple counter as the address source, and its results go to status/interrupt logic.

---
 rtl/mem_scan_checker.sv | 136 +++++++++++++
 tb/tb_mem_scan_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_checker.sv
// mem_scan_checker: sequential parity scrub engine for two 8-entry memories.
// Walks every address of bank 0, then bank 1, one location per cycle, checks
// stored parity against the XOR of the returned data byte, counts failures
// and records the first failing {bank, sel}.
//
// Build option: define SCAN_STOP_ON_ERR_EN to end the scan on the first
// failing location. The address then stays on that location until the next
// start. Without the macro every location is always checked.
module mem_scan_checker #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rd_data,
    input  logic              rd_par,
    output logic [ADDR_W-1:0] sel,
    output logic              bank,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [ADDR_W:0]   first_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]  LAST_LOC = {(ADDR_W+1){1'b1}};
    localparam logic [ADDR_W:0]  LOC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Even-parity helper: XOR of all data bits of one memory byte.
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state_r;
    logic [ADDR_W:0] loc_s;
    logic            fail_s;
    logic [CNT_W-1:0] cnt_next_s;

    assign loc_s = {bank, sel};

    // Entry check: stored parity must equal the XOR of the eight data bits.
    always_comb begin
        fail_s = rd_par ^ parity8(rd_data);
    end

    // Saturating increment of the failure counter.
    always_comb begin
        if (err_cnt == CNT_MAX) begin
            cnt_next_s = err_cnt;
        end else begin
            cnt_next_s = err_cnt + CNT_ONE;
        end
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            sel       <= {ADDR_W{1'b0}};
            bank      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= {CNT_W{1'b0}};
            err_flag  <= 1'b0;
            first_err <= {(ADDR_W+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= ST_SCAN;
                        busy      <= 1'b1;
                        sel       <= {ADDR_W{1'b0}};
                        bank      <= 1'b0;
                        err_cnt   <= {CNT_W{1'b0}};
                        err_flag  <= 1'b0;
                        first_err <= {(ADDR_W+1){1'b0}};
                    end
                end
                ST_SCAN: begin
                    if (fail_s) begin
                        err_cnt <= cnt_next_s;
                        if (!err_flag) begin
                            first_err <= loc_s;
                            err_flag  <= 1'b1;
                        end
                    end
`ifdef SCAN_STOP_ON_ERR_EN
                    if (fail_s) begin
                        // Hold the failing address for inspection.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (loc_s == LAST_LOC) begin
                        state_r       <= ST_DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        {bank, sel}   <= {(ADDR_W+1){1'b0}};
                    end else begin
                        {bank, sel}   <= loc_s + LOC_ONE;
                    end
`else
                    if (loc_s == LAST_LOC) begin
                        state_r       <= ST_DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        {bank, sel}   <= {(ADDR_W+1){1'b0}};
                    end else begin
                        {bank, sel}   <= loc_s + LOC_ONE;
                    end
`endif
                end
                ST_DONE: begin
                    // One-cycle completion pulse; start is not looked at here.
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scan_checker.sv
// Self-checking bench for mem_scan_checker: a behavioural memory model drives
// rd_data/rd_par combinationally, expected scan results are pushed to a
// scoreboard queue when a scan is started and popped on completion.
module tb_mem_scan_checker;

    localparam int ADDR_W = 3;
    localparam int CNT_W  = 5;
    localparam int LOCS   = 16;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             flag;
        logic [ADDR_W:0]  first;
        int               cycles;
        logic [ADDR_W:0]  addr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_par;
    logic [ADDR_W-1:0] sel;
    logic              bank;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_flag;
    logic [ADDR_W:0]   first_err;

    logic [7:0] mem_d [LOCS];
    logic       mem_p [LOCS];
    exp_t       sb [$];
    int         tests = 0;
    int         fails = 0;

    mem_scan_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rd_data(rd_data), .rd_par(rd_par),
        .sel(sel), .bank(bank), .busy(busy), .done(done), .err_cnt(err_cnt),
        .err_flag(err_flag), .first_err(first_err)
    );

    always #5 clk = ~clk;

    assign rd_data = mem_d[{bank, sel}];
    assign rd_par  = mem_p[{bank, sel}];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_clean();
        for (int i = 0; i < LOCS; i++) begin
            if (i < 8) begin
                mem_d[i] = 8'b00011111;
                mem_p[i] = 1'b1;
            end else begin
                mem_d[i] = 8'h3C;
                mem_p[i] = 1'b0;
            end
        end
    endtask

    // Reference model of one scan over the current memory contents.
    task automatic model_push();
        exp_t e;
        logic f;
        e.cnt    = '0;
        e.flag   = 1'b0;
        e.first  = '0;
        e.cycles = LOCS;
        e.addr   = '0;
        for (int i = 0; i < LOCS; i++) begin
            f = mem_p[i] ^ (^mem_d[i]);
            if (f) begin
                e.cnt = e.cnt + 5'd1;
                if (!e.flag) begin
                    e.flag  = 1'b1;
                    e.first = 4'(i);
`ifdef SCAN_STOP_ON_ERR_EN
                    e.cycles = i + 1;
                    e.addr   = 4'(i);
                    break;
`endif
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic run_scan(input string tag, input bit hold);
        exp_t e;
        int   n;
        model_push();
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 32'(n), 32'(e.cycles));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.cnt));
        check({tag, "_err_flag"}, 32'(err_flag), 32'(e.flag));
        check({tag, "_first_err"}, 32'(first_err), 32'(e.first));
        check({tag, "_addr"}, 32'({bank, sel}), 32'(e.addr));
        tick();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_cnt_hold"}, 32'(err_cnt), 32'(e.cnt));
    endtask

    initial begin
        fill_clean();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'({bank, sel}), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_flag", 32'(err_flag), 32'd0);
        check("rst_first", 32'(first_err), 32'd0);
        rstn = 1'b1;
        tick();
        check("idle_hold", 32'(busy), 32'd0);

        // Single corruption at bank 1, address 5.
        mem_d[13] = 8'b10101011;
        mem_p[13] = 1'b0;
        run_scan("single", 1'b0);

        // Reset during scan discards the partial result.
        fill_clean();
        mem_p[2] = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'({bank, sel}), 32'd0);
        check("mid_rst_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_flag", 32'(err_flag), 32'd0);
        check("mid_rst_first", 32'(first_err), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cnt", 32'(err_cnt), 32'd0);

        // Clean memories.
        fill_clean();
        run_scan("clean", 1'b0);

        // Three failures at {0,2}, {0,7}, {1,0}.
        mem_p[2] = 1'b0;
        mem_p[7] = 1'b0;
        mem_p[8] = 1'b1;
        run_scan("three", 1'b0);

        // start held high: back-to-back scans, start during SCAN ignored.
        fill_clean();
        mem_d[4]  = 8'h01;
        mem_d[15] = 8'h07;
        run_scan("hold_a", 1'b1);
        run_scan("hold_b", 1'b1);
        start = 1'b0;
        tick();
        check("hold_end_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
